// File: rtl/serial_loader_pkg.sv
// serial_loader_pkg: shared FSM state enum and default payload width; the PAR state exists only when SERIAL_LOADER_PARITY_EN is defined
package serial_loader_pkg;
  localparam int WIDTH_DEFAULT = 4;
  typedef enum logic [1:0] {
    IDLE,
    DATA,
`ifdef SERIAL_LOADER_PARITY_EN
    PAR,
`endif
    STOP
  } state_t;
endpackage

// File: rtl/sipo_shift.sv
// sipo_shift: LSB-first serial-in shift register; clk/clear(async) in, shift_en/sin in, q word out, count of bits shifted (returns to 0 after the WIDTH-th bit)
module sipo_shift
  import serial_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       shift_en,
  input  logic                       sin,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(WIDTH+1)-1:0] count
);
  localparam int CW = $clog2(WIDTH+1);
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q     <= '0;
      count <= '0;
    end else if (shift_en) begin
      q     <= (q >> 1) | (WIDTH'(sin) << (WIDTH - 1));
      count <= (count == CW'(WIDTH - 1)) ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/serial_loader.sv
// serial_loader: framed serial receiver (start 0, WIDTH bits LSB first, optional even parity with SERIAL_LOADER_PARITY_EN, stop 1); clk/clear(async)/sin/sin_valid in, data/load/busy/err registered out
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] data,
  output logic             load,
  output logic             busy,
  output logic             err
);
  localparam int CW = $clog2(WIDTH+1);
  state_t           state;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;
  logic             shift_en;
  logic             last;
  logic             ok;
  assign shift_en = sin_valid && state == DATA;
  assign last     = count == CW'(WIDTH - 1);
`ifdef SERIAL_LOADER_PARITY_EN
  logic perr;
  assign ok = sin && !perr;
`else
  assign ok = sin;
`endif
  sipo_shift #(.WIDTH(WIDTH)) u_sipo (
    .clk      (clk),
    .clear    (clear),
    .shift_en (shift_en),
    .sin      (sin),
    .q        (q),
    .count    (count)
  );
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      data  <= '0;
      load  <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
      perr  <= 1'b0;
`endif
    end else begin
      load <= 1'b0;
      err  <= 1'b0;
      if (sin_valid) begin
        case (state)
          IDLE: if (!sin) begin
            state <= DATA;
            busy  <= 1'b1;
          end
`ifdef SERIAL_LOADER_PARITY_EN
          DATA: if (last) state <= PAR;
          PAR: begin
            perr  <= ^q ^ sin;
            state <= STOP;
          end
`else
          DATA: if (last) state <= STOP;
`endif
          STOP: begin
            if (ok) begin
              data <= q;
              load <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
            perr  <= 1'b0;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader: directed frames against serial_loader with hand-computed strobes, busy cycles and data words
module tb_serial_loader;
`ifdef SERIAL_LOADER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int W  = 4;
  localparam int NB = W + 1 + PB;
  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         sin = 1'b1;
  logic         sin_valid = 1'b0;
  logic [W-1:0] data;
  logic         load;
  logic         busy;
  logic         err;
  int           nvec = 0;
  int           nmis = 0;
  int           nload, nerr, nbusy, nboth;
  serial_loader #(.WIDTH(W)) dut (
    .clk       (clk),
    .clear     (clear),
    .sin       (sin),
    .sin_valid (sin_valid),
    .data      (data),
    .load      (load),
    .busy      (busy),
    .err       (err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tally_reset();
    nload = 0;
    nerr  = 0;
    nbusy = 0;
    nboth = 0;
  endtask
  task automatic step(input logic v, input logic s);
    @(negedge clk);
    sin_valid = v;
    sin = s;
    @(posedge clk);
    #1;
    nload += int'(load);
    nerr  += int'(err);
    nbusy += int'(busy);
    nboth += int'(load && err);
  endtask
  task automatic bit_in(input logic s, input int gap);
    for (int g = 0; g < gap; g++) step(1'b0, 1'b1);
    step(1'b1, s);
  endtask
  task automatic send_frame(input logic [W-1:0] word, input logic stop, input logic pflip, input int gap);
    bit_in(1'b0, gap);
    for (int i = 0; i < W; i++) bit_in(word[i], gap);
    if (PB == 1) bit_in((^word) ^ pflip, gap);
    bit_in(stop, gap);
  endtask
  initial begin
    #1;
    check("reset_data", 32'(data), 32'h0);
    check("reset_load", 32'(load), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    clear = 1'b0;
    tally_reset();
    send_frame(4'b0101, 1'b1, 1'b0, 0);
    check("good_load", 32'(nload), 32'd1);
    check("good_err", 32'(nerr), 32'd0);
    check("good_busy", 32'(nbusy), 32'(NB));
    check("good_data", 32'(data), 32'h5);
    step(1'b0, 1'b1);
    check("good_load_1cyc", 32'(load), 32'h0);
    tally_reset();
    send_frame(4'b1001, 1'b0, 1'b0, 0);
    check("badstop_err", 32'(nerr), 32'd1);
    check("badstop_load", 32'(nload), 32'd0);
    check("badstop_data", 32'(data), 32'h5);
    step(1'b0, 1'b1);
    check("badstop_err_1cyc", 32'(err), 32'h0);
    tally_reset();
    send_frame(4'b0101, 1'b1, 1'b0, 0);
    check("b2b_first_data", 32'(data), 32'h5);
    check("b2b_first_load", 32'(load), 32'h1);
    send_frame(4'b1001, 1'b1, 1'b0, 0);
    check("b2b_loads", 32'(nload), 32'd2);
    check("b2b_errs", 32'(nerr), 32'd0);
    check("b2b_second_data", 32'(data), 32'h9);
    tally_reset();
    bit_in(1'b0, 0);
    bit_in(1'b1, 0);
    bit_in(1'b1, 0);
    check("abort_busy_before", 32'(busy), 32'h1);
    @(negedge clk);
    clear = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_data", 32'(data), 32'h0);
    @(negedge clk);
    clear = 1'b0;
    step(1'b1, 1'b1);
    check("abort_idle_after", 32'(busy), 32'h0);
    send_frame(4'b0011, 1'b1, 1'b0, 0);
    check("abort_loads", 32'(nload), 32'd1);
    check("abort_errs", 32'(nerr), 32'd0);
    check("abort_new_data", 32'(data), 32'h3);
    tally_reset();
    send_frame(4'b0101, 1'b1, 1'b0, 3);
    check("gap_loads", 32'(nload), 32'd1);
    check("gap_errs", 32'(nerr), 32'd0);
    check("gap_busy", 32'(nbusy), 32'(NB * 4));
    check("gap_data", 32'(data), 32'h5);
    tally_reset();
    send_frame(4'b0110, 1'b1, 1'b0, 0);
    check("plain_data", 32'(data), 32'h6);
    send_frame(4'b1111, 1'b1, 1'b1, 0);
    if (PB == 1) begin
      check("parity_bad_err", 32'(nerr), 32'd1);
      check("parity_bad_loads", 32'(nload), 32'd1);
      check("parity_bad_data", 32'(data), 32'h6);
      send_frame(4'b0101, 1'b1, 1'b0, 0);
      check("parity_good_data", 32'(data), 32'h5);
      check("parity_good_loads", 32'(nload), 32'd2);
    end else begin
      check("flip_ignored_loads", 32'(nload), 32'd2);
      check("flip_ignored_data", 32'(data), 32'hf);
    end
    check("never_both", 32'(nboth), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
